// File: rtl/cv32e40p_ft_nmr_guard.sv
// N-modular redundancy voter with leaky-bucket channel health tracking,
// graceful NMR/DMR/simplex/fail degradation and software reintegration.
module cv32e40p_ft_nmr_guard #(
   parameter int NCH       = 3,
   parameter int W         = 32,
   parameter int INCREMENT = 4,
   parameter int DECREMENT = 1,
   parameter int THRESHOLD = 12,
   parameter int COUNT_BIT = 5,
   parameter int STAT_BIT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic [NCH*W-1:0]    to_vote_i,
   input  logic [NCH-1:0]      set_broken_i,
   input  logic [NCH-1:0]      clr_broken_i,
   output logic                valid_o,
   output logic [W-1:0]        voted_o,
   output logic [1:0]          mode_o,
   output logic [NCH-1:0]      is_broken_o,
   output logic                err_detected_o,
   output logic                err_corrected_o,
   output logic                uncorrectable_o,
   output logic [STAT_BIT-1:0] stat_corrected_o
);

   typedef enum logic [1:0] {
      M_NMR     = 2'd0,
      M_DMR     = 2'd1,
      M_SIMPLEX = 2'd2,
      M_FAIL    = 2'd3
   } mode_e;

   // 4 bits hold 2*NCH for NCH up to 7
   localparam int CW = 4;

   localparam logic [COUNT_BIT:0] LP_MAX = {1'b0, {COUNT_BIT{1'b1}}};
   localparam logic [COUNT_BIT:0] LP_INC = (COUNT_BIT+1)'(INCREMENT);
   localparam logic [COUNT_BIT:0] LP_DEC = (COUNT_BIT+1)'(DECREMENT);
   localparam logic [COUNT_BIT:0] LP_THR = (COUNT_BIT+1)'(THRESHOLD);

   logic                r_valid;
   logic [W-1:0]        r_voted;
   mode_e               r_mode;
   logic [NCH-1:0]      r_broken;
   logic                r_det;
   logic                r_corr;
   logic                r_unc;
   logic [STAT_BIT-1:0] r_stat;
   logic [COUNT_BIT-1:0] r_cnt [NCH];

   logic [CW-1:0]        w_h;
   logic [W-1:0]         w_voted;
   logic                 w_tie;
   logic [NCH-1:0]       w_mm;
   logic                 w_unc;
   logic                 w_det;
   logic                 w_corr;
   logic                 w_nmr;
   logic [COUNT_BIT-1:0] w_cnt_nx [NCH];
   logic [NCH-1:0]       w_broken_nx;
   logic [CW-1:0]        w_hn;
   mode_e                w_mode_nx;

   always_comb begin : p_vote
      logic [CW-1:0] w_ones;
      logic          w_low;
      logic          w_fnd;
      w_ones  = '0;
      w_low   = 1'b0;
      w_fnd   = 1'b0;
      w_h     = '0;
      w_voted = '0;
      w_tie   = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (!r_broken[k]) w_h = w_h + CW'(1);
      end
      for (int b = 0; b < W; b++) begin
         w_ones = '0;
         w_low  = 1'b0;
         w_fnd  = 1'b0;
         for (int k = 0; k < NCH; k++) begin
            if (!r_broken[k]) begin
               if (to_vote_i[k*W+b]) w_ones = w_ones + CW'(1);
               if (!w_fnd) begin
                  w_low = to_vote_i[k*W+b];
                  w_fnd = 1'b1;
               end
            end
         end
         if ((w_ones << 1) > w_h) begin
            w_voted[b] = 1'b1;
         end else if (((w_h - w_ones) << 1) > w_h) begin
            w_voted[b] = 1'b0;
         end else begin
            // tie (or no healthy channel): lowest healthy index wins
            w_voted[b] = w_low;
            w_tie      = 1'b1;
         end
      end
   end

   always_comb begin
      w_mm = '0;
      for (int k = 0; k < NCH; k++) begin
         w_mm[k] = !r_broken[k] && (to_vote_i[k*W +: W] != w_voted);
      end
   end

   assign w_unc  = w_tie && (w_h >= CW'(2));
   assign w_det  = (|w_mm) || w_unc;
   assign w_corr = w_det && !w_unc;
   assign w_nmr  = (w_h >= CW'(3));

   always_comb begin : p_health
      logic [COUNT_BIT:0] w_sum;
      w_sum       = '0;
      w_broken_nx = r_broken;
      for (int k = 0; k < NCH; k++) begin
         w_sum       = {1'b0, r_cnt[k]} + LP_INC;
         w_cnt_nx[k] = r_cnt[k];
         if (valid_i && w_nmr && !r_broken[k]) begin
            if (w_mm[k]) begin
               w_cnt_nx[k] = (w_sum > LP_MAX) ? LP_MAX[COUNT_BIT-1:0]
                                              : w_sum[COUNT_BIT-1:0];
            end else if ({1'b0, r_cnt[k]} >= LP_DEC) begin
               w_cnt_nx[k] = COUNT_BIT'({1'b0, r_cnt[k]} - LP_DEC);
            end else begin
               w_cnt_nx[k] = '0;
            end
         end
         w_broken_nx[k] = r_broken[k] || ({1'b0, w_cnt_nx[k]} >= LP_THR);
         // set wins over clear, clear wins over a threshold crossing
         if (clr_broken_i[k] && !set_broken_i[k]) begin
            w_broken_nx[k] = 1'b0;
            w_cnt_nx[k]    = '0;
         end
         if (set_broken_i[k]) w_broken_nx[k] = 1'b1;
      end
   end

   always_comb begin
      w_hn = '0;
      for (int k = 0; k < NCH; k++) begin
         if (!w_broken_nx[k]) w_hn = w_hn + CW'(1);
      end
      if (w_hn >= CW'(3))      w_mode_nx = M_NMR;
      else if (w_hn == CW'(2)) w_mode_nx = M_DMR;
      else if (w_hn == CW'(1)) w_mode_nx = M_SIMPLEX;
      else                     w_mode_nx = M_FAIL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_voted  <= '0;
         r_mode   <= M_NMR;
         r_broken <= '0;
         r_det    <= 1'b0;
         r_corr   <= 1'b0;
         r_unc    <= 1'b0;
         r_stat   <= '0;
         for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
      end else begin
         r_valid  <= valid_i;
         r_mode   <= w_mode_nx;
         r_broken <= w_broken_nx;
         for (int k = 0; k < NCH; k++) r_cnt[k] <= w_cnt_nx[k];
         if (valid_i) begin
            r_voted <= w_voted;
            r_det   <= w_det;
            r_corr  <= w_corr;
            r_unc   <= w_unc;
            if (w_corr && (r_stat != {STAT_BIT{1'b1}})) begin
               r_stat <= r_stat + STAT_BIT'(1);
            end
         end else begin
            r_det  <= 1'b0;
            r_corr <= 1'b0;
            r_unc  <= 1'b0;
         end
      end
   end

   assign valid_o          = r_valid;
   assign voted_o          = r_voted;
   assign mode_o           = r_mode;
   assign is_broken_o      = r_broken;
   assign err_detected_o   = r_det;
   assign err_corrected_o  = r_corr;
   assign uncorrectable_o  = r_unc;
   assign stat_corrected_o = r_stat;

endmodule

// File: tb/tb_cv32e40p_ft_nmr_guard.sv
// Scoreboard bench for the NMR guard: NCH=3/W=32 and NCH=4/W=8 instances.
// Stimulus pushes expectations; per-DUT monitors pop on valid_o.
module tb_cv32e40p_ft_nmr_guard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v3;
   logic [95:0] tv3;
   logic [2:0]  sb3, cb3;
   logic        vo3, de3, co3, un3;
   logic [31:0] vd3;
   logic [1:0]  md3;
   logic [2:0]  br3;
   logic [15:0] st3;

   logic        v4;
   logic [31:0] tv4;
   logic [3:0]  sb4, cb4;
   logic        vo4, de4, co4, un4;
   logic [7:0]  vd4;
   logic [1:0]  md4;
   logic [3:0]  br4;
   logic [15:0] st4;

   cv32e40p_ft_nmr_guard #(.NCH(3), .W(32)) u_dut3 (
      .clk(clk), .rst(rst), .valid_i(v3), .to_vote_i(tv3),
      .set_broken_i(sb3), .clr_broken_i(cb3),
      .valid_o(vo3), .voted_o(vd3), .mode_o(md3), .is_broken_o(br3),
      .err_detected_o(de3), .err_corrected_o(co3),
      .uncorrectable_o(un3), .stat_corrected_o(st3)
   );

   cv32e40p_ft_nmr_guard #(.NCH(4), .W(8)) u_dut4 (
      .clk(clk), .rst(rst), .valid_i(v4), .to_vote_i(tv4),
      .set_broken_i(sb4), .clr_broken_i(cb4),
      .valid_o(vo4), .voted_o(vd4), .mode_o(md4), .is_broken_o(br4),
      .err_detected_o(de4), .err_corrected_o(co4),
      .uncorrectable_o(un4), .stat_corrected_o(st4)
   );

   typedef struct packed {
      logic        vld;
      logic [31:0] voted;
      logic [1:0]  mode;
      logic [3:0]  brk;
      logic        det;
      logic        corr;
      logic        unc;
      logic [15:0] stat;
   } exp_t;

   exp_t q3[$];
   exp_t q4[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   k3 = 0;
   int   k4 = 0;

   function automatic exp_t mk(logic [31:0] vd, logic [1:0] m,
                               logic [3:0] b, logic d, logic c,
                               logic u, logic [15:0] s);
      exp_t e;
      e = '{vld: 1'b1, voted: vd, mode: m, brk: b,
            det: d, corr: c, unc: u, stat: s};
      return e;
   endfunction

   function automatic exp_t a3();
      return exp_t'({vo3, vd3, md3, 1'b0, br3, de3, co3, un3, st3});
   endfunction

   function automatic exp_t a4();
      return exp_t'({vo4, 24'h0, vd4, md4, br4, de4, co4, un4, st4});
   endfunction

   task automatic check(string name, exp_t a, exp_t e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got v=%b d=%h m=%0d b=%b dcu=%b%b%b s=%0d, want v=%b d=%h m=%0d b=%b dcu=%b%b%b s=%0d",
                  name, a.vld, a.voted, a.mode, a.brk, a.det, a.corr,
                  a.unc, a.stat, e.vld, e.voted, e.mode, e.brk, e.det,
                  e.corr, e.unc, e.stat);
      end
   endtask

   always @(negedge clk) begin
      if (vo3) begin
         if (q3.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut3 unexpected output: got d=%h, want none", vd3);
         end else begin
            check($sformatf("dut3 vec %0d", k3), a3(), q3.pop_front());
            k3++;
         end
      end
      if (vo4) begin
         if (q4.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut4 unexpected output: got d=%h, want none", vd4);
         end else begin
            check($sformatf("dut4 vec %0d", k4), a4(), q4.pop_front());
            k4++;
         end
      end
   end

   task automatic drv3(logic v, logic [31:0] c0, logic [31:0] c1,
                       logic [31:0] c2, logic [2:0] sb, logic [2:0] cb,
                       exp_t e);
      @(negedge clk);
      #1;
      v3  = v;
      tv3 = {c2, c1, c0};
      sb3 = sb;
      cb3 = cb;
      if (v) q3.push_back(e);
   endtask

   task automatic drv4(logic v, logic [7:0] c0, logic [7:0] c1,
                       logic [7:0] c2, logic [7:0] c3, exp_t e);
      @(negedge clk);
      #1;
      v4  = v;
      tv4 = {c3, c2, c1, c0};
      if (v) q4.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before 200us");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      v3 = 1'b0; tv3 = '0; sb3 = '0; cb3 = '0;
      v4 = 1'b0; tv4 = '0; sb4 = '0; cb4 = '0;
      repeat (2) @(negedge clk);
      check("reset dut3", a3(), exp_t'('0));
      check("reset dut4", a4(), exp_t'('0));
      #1 rst = 1'b0;

      drv4(1, 8'h01, 8'h01, 8'h00, 8'h00, mk(32'h01, 0, 4'b0000, 1, 0, 1, 0));
      drv4(1, 8'hF0, 8'h0F, 8'h0F, 8'h0F, mk(32'h0F, 0, 4'b0000, 1, 1, 0, 1));
      drv4(1, 8'h3C, 8'h3C, 8'h3C, 8'h3C, mk(32'h3C, 0, 4'b0000, 0, 0, 0, 1));
      drv4(0, 8'h00, 8'h00, 8'h00, 8'h00, exp_t'('0));

      drv3(1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0,
           mk(32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
      drv3(1, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 0, 0,
           mk(32'hA5A5A5A5, 0, 0, 1, 1, 0, 1));
      drv3(1, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 0, 0,
           mk(32'hA5A5A5A5, 0, 0, 1, 1, 0, 2));
      drv3(1, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 0, 0,
           mk(32'hA5A5A5A5, 1, 4'b0010, 1, 1, 0, 3));
      drv3(1, 32'h1, 32'hFFFF, 32'h2, 0, 0,
           mk(32'h1, 1, 4'b0010, 1, 0, 1, 3));
      drv3(1, 32'h1234, 32'h0, 32'h1234, 0, 0,
           mk(32'h1234, 1, 4'b0010, 0, 0, 0, 3));
      drv3(1, 32'h55, 32'h55, 32'h55, 0, 3'b010,
           mk(32'h55, 0, 0, 0, 0, 0, 3));
      drv3(1, 32'h0, 32'h77, 32'h77, 0, 0,
           mk(32'h77, 0, 0, 1, 1, 0, 4));
      for (int i = 0; i < 4; i++) begin
         drv3(1, 32'h77, 32'h77, 32'h77, 0, 0,
              mk(32'h77, 0, 0, 0, 0, 0, 4));
      end
      drv3(1, 32'h0, 32'h77, 32'h77, 0, 0,
           mk(32'h77, 0, 0, 1, 1, 0, 5));
      drv3(1, 32'h0, 32'h77, 32'h77, 0, 0,
           mk(32'h77, 0, 0, 1, 1, 0, 6));
      drv3(1, 32'h0, 32'h77, 32'h77, 0, 0,
           mk(32'h77, 1, 4'b0001, 1, 1, 0, 7));
      drv3(1, 32'h99, 32'h99, 32'h99, 3'b111, 0,
           mk(32'h99, 3, 4'b0111, 0, 0, 0, 7));
      drv3(1, 32'h99, 32'h99, 32'h99, 0, 0,
           mk(32'h0, 3, 4'b0111, 0, 0, 0, 7));
      drv3(1, 32'h0, 32'h0, 32'hCAFE, 0, 3'b100,
           mk(32'h0, 2, 4'b0011, 0, 0, 0, 7));
      drv3(1, 32'h0, 32'h0, 32'hBEEF, 0, 0,
           mk(32'hBEEF, 2, 4'b0011, 0, 0, 0, 7));
      drv3(1, 32'h0, 32'h0, 32'h1111, 3'b100, 3'b100,
           mk(32'h1111, 3, 4'b0111, 0, 0, 0, 7));
      drv3(1, 32'h42, 32'h42, 32'h42, 0, 0,
           mk(32'h0, 3, 4'b0111, 0, 0, 0, 7));
      drv3(1, 32'h42, 32'h42, 32'h42, 0, 3'b111,
           mk(32'h0, 0, 0, 0, 0, 0, 7));
      drv3(1, 32'h42, 32'h42, 32'h42, 0, 0,
           mk(32'h42, 0, 0, 0, 0, 0, 7));
      drv3(0, 32'h13, 32'h0, 32'h13, 0, 0, exp_t'('0));
      @(negedge clk);
      begin
         exp_t e;
         e = mk(32'h42, 0, 0, 0, 0, 0, 7);
         e.vld = 1'b0;
         check("hold on idle", a3(), e);
      end

      #1;
      rst = 1'b1;
      v3  = 1'b1;
      tv3 = {32'h5, 32'h6, 32'h7};
      @(negedge clk);
      check("mid-stream reset", a3(), exp_t'('0));
      #1;
      rst = 1'b0;
      v3  = 1'b0;

      repeat (3) @(negedge clk);
      if (q3.size() != 0 || q4.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL pending outputs: got %0d/%0d left, want 0/0",
                  q3.size(), q4.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
